// File: rtl/mul_shift_add_pkg.sv
// ============================================================================
// mul_shift_add_pkg : shared calculator types and constants for the multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

package mul_shift_add_pkg;

  localparam int OPW = 16;
  localparam logic [3:0] ITER_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_shift_add_add16.sv
// ============================================================================
// add16 : combinational 16-bit ripple adder, generate/propagate carry form
// Revision: 1.0
// ============================================================================
`default_nettype none

module add16
  import mul_shift_add_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           cin,
  output logic [OPW-1:0] sum,
  output logic           cout
);

  logic [OPW-1:0] gen;
  logic [OPW-1:0] prop;
  logic [OPW:0]   carry;

  assign gen      = a & b;
  assign prop     = a ^ b;
  assign carry[0] = cin;

  generate
    for (genvar i = 0; i < OPW; i++) begin : g_carry
      assign carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  endgenerate

  assign sum  = prop ^ carry[OPW-1:0];
  assign cout = carry[OPW];

endmodule

`default_nettype wire

// File: rtl/mul_shift_add.sv
// ============================================================================
// mul_shift_add : sequential 16x16 unsigned shift-and-add multiplier, 16 cycles
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_shift_add
  import mul_shift_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [2*OPW-1:0] product,
  output logic             overflow
);

  state_t           state;
  logic [OPW-1:0]   mcand;
  logic [2*OPW-1:0] acc;
  logic [3:0]       cnt;

  logic [OPW-1:0]   addend;
  logic [OPW-1:0]   sum;
  logic             cout;
  logic [2*OPW-1:0] acc_next;

  assign addend = acc[0] ? mcand : '0;

  add16 u_add16 (
    .a    (acc[2*OPW-1:OPW]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry re-enters at bit 31 as the partial sum shifts right, so no bit is lost
  assign acc_next = {cout, sum, acc[OPW-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            acc   <= {{OPW{1'b0}}, b};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 4'd1;
          if (cnt == ITER_LAST) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            product  <= acc_next;
            overflow <= |acc_next[2*OPW-1:OPW];
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_shift_add.sv
// ============================================================================
// tb_mul_shift_add : directed + random scoreboard bench for mul_shift_add
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul_shift_add;

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        overflow;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  mul_shift_add dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    e.prod = 32'(x) * 32'(y);
    e.ovf  = (e.prod > 32'h0000FFFF);
    exp_q.push_back(e);
  endtask

  // Entered at a falling edge; returns at the falling edge after the accepting edge
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input bit push);
    start = 1'b1;
    a     = x;
    b     = y;
    if (push) push_exp(x, y);
    @(negedge clk);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input bit drop);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, exp_lat);
    check("busy_in_done", {31'b0, busy}, 32'd0);
    e = exp_q.pop_front();
    check("product", product, e.prod);
    check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
    if (drop) start = 1'b0;
    @(negedge clk);
    check("done_single_pulse", {31'b0, done}, 32'd0);
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y);
    start_op(x, y, 1'b1);
    wait_done(16, 1'b0);
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_product", product, 32'h0);
    check("reset_overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'd3, 16'd5);
    do_op(16'hFFFF, 16'hFFFF);
    do_op(16'h0000, 16'h1234);
    do_op(16'h1234, 16'h0000);
    do_op(16'h8000, 16'h0002);

    // Back-to-back with start held continuously
    start = 1'b1;
    a     = 16'd7;
    b     = 16'd9;
    repeat (3) push_exp(16'd7, 16'd9);
    @(negedge clk);
    wait_done(16, 1'b0);
    wait_done(16, 1'b0);
    wait_done(16, 1'b1);
    check("idle_after_b2b", {31'b0, busy}, 32'd0);

    // Inputs and start during RUN must not disturb the operation in flight
    start_op(16'd11, 16'd13, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, 1'b0);

    // Reset on the 8th RUN cycle aborts; no done follows
    start_op(16'd100, 16'd200, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_product", product, 32'h0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    do_op(16'd100, 16'd200);

    // Reset together with start: start is dropped
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'd5;
    b     = 16'd5;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_beats_start", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      do_op(16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
